// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: JTAG (m1) has fixed priority, the core (m0) is protected from
// starvation, and a stalled slave is completed with an error after TIMEOUT busy cycles.
module bus_arbiter #(
    parameter int unsigned TIMEOUT  = 256,
    parameter int unsigned MAX_WAIT = 4,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        m0_req_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_data_i,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_data_o,
    input  logic        m1_req_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_data_i,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_data_o,
    output logic        s_req_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_addr_o,
    output logic        s_we_o,
    output logic [31:0] s_data_o,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_data_i,
    output logic [1:0]  grant_o,
    output logic        err_o
);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT);
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;

    logic        busy;
    logic        tmo_hit;
    logic        done;
    logic [31:0] rdata;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        s_req_o     = 1'b0;
        s_sel_o     = '0;
        s_addr_o    = '0;
        s_we_o      = 1'b0;
        s_data_o    = '0;
        grant_o     = 2'b00;
        m0_rvalid_o = 1'b0;
        m1_rvalid_o = 1'b0;
        m0_data_o   = '0;
        m1_data_o   = '0;

        busy    = (state_q != IDLE);
        // A real response in the final cycle beats the timeout.
        tmo_hit = busy && !s_rvalid_i && (tmo_cnt_q == TMO_LAST);
        done    = busy && (s_rvalid_i || tmo_hit);
        rdata   = s_rvalid_i ? s_data_i : ERR_DATA;
        err_o   = tmo_hit;

        case (state_q)
            IDLE: begin
                tmo_cnt_d = '0;
                if (m1_req_i && !(m0_req_i && wait_cnt_q == WAIT_LIMIT)) begin
                    state_d = BUSY1;
                    if (!m0_req_i) begin
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q != WAIT_LIMIT) begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end else if (m0_req_i) begin
                    state_d    = BUSY0;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = '0;
                end
            end
            BUSY0: begin
                s_req_o     = 1'b1;
                s_sel_o     = m0_sel_i;
                s_addr_o    = m0_addr_i;
                s_we_o      = m0_we_i;
                s_data_o    = m0_data_i;
                grant_o     = 2'b01;
                m0_rvalid_o = done;
                m0_data_o   = done ? rdata : '0;
            end
            BUSY1: begin
                s_req_o     = 1'b1;
                s_sel_o     = m1_sel_i;
                s_addr_o    = m1_addr_i;
                s_we_o      = m1_we_i;
                s_data_o    = m1_data_i;
                grant_o     = 2'b10;
                m1_rvalid_o = done;
                m1_data_o   = done ? rdata : '0;
            end
            default: state_d = IDLE;
        endcase

        // Completion always passes through IDLE, forcing one idle bus cycle.
        if (busy) begin
            if (done) begin
                state_d   = IDLE;
                tmo_cnt_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end
    end

endmodule
